// File: rtl/sm_fetch_pkg.sv
// Shared types and default widths for the SM multi-warp fetch unit.
package sm_fetch_pkg;

   localparam int DEF_NUM_WARP   = 8;
   localparam int DEF_WID_W      = $clog2(DEF_NUM_WARP);
   localparam int DEF_PC_WIDTH   = 32;
   localparam int DEF_INST_WIDTH = 64;
   localparam int DEF_INST_BYTES = 8;

   typedef struct packed {
      logic [DEF_PC_WIDTH-1:0] addr;
      logic [DEF_WID_W-1:0]    wid;
      logic                    tag;
   } fetch_req_t;

   typedef struct packed {
      logic [DEF_WID_W-1:0]      wid;
      logic                      tag;
      logic [DEF_INST_WIDTH-1:0] data;
   } fetch_rsp_t;

   typedef struct packed {
      logic                    active;
      logic                    inflight;
      logic                    epoch;
      logic [DEF_PC_WIDTH-1:0] pc;
      logic [DEF_PC_WIDTH-1:0] inflight_pc;
   } warp_state_t;

endpackage

// File: rtl/sm_fetch_mw_fetch_rr_arb.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the winner.
module fetch_rr_arb
   import sm_fetch_pkg::*;
#(
   parameter int NUM_WARP = DEF_NUM_WARP,
   parameter int WID_W    = $clog2(NUM_WARP)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_WARP-1:0] req_i,
   input  logic                adv_i,
   output logic [NUM_WARP-1:0] gnt_o,
   output logic [WID_W-1:0]    idx_o
);

   logic [WID_W-1:0] ptr_q;
   logic             found;
   int               j;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < NUM_WARP; i++) begin
         j = int'(ptr_q) + i;
         if (j >= NUM_WARP) j = j - NUM_WARP;
         if (!found && req_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = WID_W'(j);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (adv_i) begin
         if (int'(idx_o) == NUM_WARP - 1) ptr_q <= '0;
         else                             ptr_q <= idx_o + 1'b1;
      end
   end

endmodule

// File: rtl/sm_fetch_mw.sv
// Multi-warp fetch: RR warp pick, registered code-read slot, epoch-tagged
// responses so redirected or killed warps drop their stale fetch.
module sm_fetch_mw
   import sm_fetch_pkg::*;
#(
   parameter int NUM_WARP   = DEF_NUM_WARP,
   parameter int WID_W      = $clog2(NUM_WARP),
   parameter int PC_WIDTH   = DEF_PC_WIDTH,
   parameter int INST_WIDTH = DEF_INST_WIDTH,
   parameter int INST_BYTES = DEF_INST_BYTES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  launch_valid_i,
   input  logic [WID_W-1:0]      launch_wid_i,
   input  logic [PC_WIDTH-1:0]   launch_pc_i,
   input  logic                  kill_valid_i,
   input  logic [WID_W-1:0]      kill_wid_i,
   input  logic                  redirect_valid_i,
   input  logic [WID_W-1:0]      redirect_wid_i,
   input  logic [PC_WIDTH-1:0]   redirect_pc_i,
   input  logic [NUM_WARP-1:0]   stall_i,
   input  logic [NUM_WARP-1:0]   ibuf_avail_i,
   output logic                  mem_req_valid_o,
   input  logic                  mem_req_ready_i,
   output logic [PC_WIDTH-1:0]   mem_req_addr_o,
   output logic [WID_W-1:0]      mem_req_wid_o,
   output logic                  mem_req_tag_o,
   input  logic                  mem_rsp_valid_i,
   input  logic [WID_W-1:0]      mem_rsp_wid_i,
   input  logic                  mem_rsp_tag_i,
   input  logic [INST_WIDTH-1:0] mem_rsp_data_i,
   output logic                  ibuf_wr_valid_o,
   output logic [WID_W-1:0]      ibuf_wr_wid_o,
   output logic [PC_WIDTH-1:0]   ibuf_wr_pc_o,
   output logic [INST_WIDTH-1:0] ibuf_wr_inst_o,
   output logic [NUM_WARP-1:0]   active_o
);

   logic [NUM_WARP-1:0]   active_q, inflight_q, epoch_q;
   logic [PC_WIDTH-1:0]   pc_q  [NUM_WARP];
   logic [PC_WIDTH-1:0]   ipc_q [NUM_WARP];

   logic                  req_valid_q, req_tag_q;
   logic [PC_WIDTH-1:0]   req_addr_q;
   logic [WID_W-1:0]      req_wid_q;
   logic                  wr_valid_q;
   logic [WID_W-1:0]      wr_wid_q;
   logic [PC_WIDTH-1:0]   wr_pc_q;
   logic [INST_WIDTH-1:0] wr_inst_q;

   logic [NUM_WARP-1:0]   kill_hit, launch_hit, redir_hit, rsp_hit;
   logic [NUM_WARP-1:0]   elig, gnt;
   logic [WID_W-1:0]      gidx;
   logic                  load, fwd;

   always_comb begin
      kill_hit   = '0;
      launch_hit = '0;
      redir_hit  = '0;
      rsp_hit    = '0;
      elig       = '0;
      for (int w = 0; w < NUM_WARP; w++) begin
         kill_hit[w]   = kill_valid_i && kill_wid_i == WID_W'(w);
         launch_hit[w] = launch_valid_i && launch_wid_i == WID_W'(w);
         redir_hit[w]  = redirect_valid_i && redirect_wid_i == WID_W'(w);
         rsp_hit[w]    = mem_rsp_valid_i && mem_rsp_wid_i == WID_W'(w);
         elig[w] = active_q[w] & ~inflight_q[w] & ~stall_i[w]
                 & ibuf_avail_i[w] & ~kill_hit[w] & ~redir_hit[w];
      end
   end

   assign load = (~req_valid_q | mem_req_ready_i) & (|elig);

   // Forward only a live response: warp still active and epoch unchanged.
   assign fwd = mem_rsp_valid_i & active_q[mem_rsp_wid_i]
              & inflight_q[mem_rsp_wid_i]
              & (mem_rsp_tag_i == epoch_q[mem_rsp_wid_i]);

   fetch_rr_arb #(
      .NUM_WARP (NUM_WARP),
      .WID_W    (WID_W)
   ) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (elig),
      .adv_i (load),
      .gnt_o (gnt),
      .idx_o (gidx)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active_q    <= '0;
         inflight_q  <= '0;
         epoch_q     <= '0;
         for (int w = 0; w < NUM_WARP; w++) begin
            pc_q[w]  <= '0;
            ipc_q[w] <= '0;
         end
         req_valid_q <= 1'b0;
         req_addr_q  <= '0;
         req_wid_q   <= '0;
         req_tag_q   <= 1'b0;
         wr_valid_q  <= 1'b0;
         wr_wid_q    <= '0;
         wr_pc_q     <= '0;
         wr_inst_q   <= '0;
      end else begin
         for (int w = 0; w < NUM_WARP; w++) begin
            if (kill_hit[w]) begin
               active_q[w] <= 1'b0;
               epoch_q[w]  <= ~epoch_q[w];
            end else if (launch_hit[w] && !active_q[w]) begin
               active_q[w] <= 1'b1;
               pc_q[w]     <= launch_pc_i;
               epoch_q[w]  <= ~epoch_q[w];
            end else if (redir_hit[w] && active_q[w]) begin
               pc_q[w]     <= redirect_pc_i;
               epoch_q[w]  <= ~epoch_q[w];
            end else if (load && gnt[w]) begin
               pc_q[w]     <= pc_q[w] + PC_WIDTH'(INST_BYTES);
            end
            if (load && gnt[w]) begin
               inflight_q[w] <= 1'b1;
               ipc_q[w]      <= pc_q[w];
            end else if (rsp_hit[w]) begin
               inflight_q[w] <= 1'b0;
            end
         end
         if (load) begin
            req_valid_q <= 1'b1;
            req_addr_q  <= pc_q[gidx];
            req_wid_q   <= gidx;
            req_tag_q   <= epoch_q[gidx];
         end else if (mem_req_ready_i) begin
            req_valid_q <= 1'b0;
         end
         wr_valid_q <= fwd;
         if (fwd) begin
            wr_wid_q  <= mem_rsp_wid_i;
            wr_pc_q   <= ipc_q[mem_rsp_wid_i];
            wr_inst_q <= mem_rsp_data_i;
         end
      end
   end

   assign mem_req_valid_o = req_valid_q;
   assign mem_req_addr_o  = req_addr_q;
   assign mem_req_wid_o   = req_wid_q;
   assign mem_req_tag_o   = req_tag_q;
   assign ibuf_wr_valid_o = wr_valid_q;
   assign ibuf_wr_wid_o   = wr_wid_q;
   assign ibuf_wr_pc_o    = wr_pc_q;
   assign ibuf_wr_inst_o  = wr_inst_q;
   assign active_o        = active_q;

endmodule
